// File: rtl/mont_mul_param.sv
`default_nettype none
// ============================================================================
//  Module   : mont_mul_param
//  Purpose  : Iterative Montgomery multiplier over GF(P). It computes
//             result = a * b * 2^-WIDTH mod P and consumes DPC bits of the
//             multiplicand a on each clock.
//  Ports    : clk    - rising-edge clock
//             reset  - synchronous, active-high reset
//             start  - operation request, sampled only while idle
//             a, b   - operands (each < P), captured when start is accepted
//             P      - odd modulus, captured when start is accepted
//             busy   - high while an operation is in flight
//             done   - one-cycle pulse when result/err are updated
//             err    - the captured modulus was even (valid together with done)
//             result - fully reduced product, held until the next done
//  Revision : 1.0 - initial release
// ============================================================================
module mont_mul_param #(
   parameter int WIDTH = 255,
   parameter int DPC   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] P,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   localparam int ITER = WIDTH / DPC;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FINAL = 2'd2
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   a_q, b_q, p_q;
   logic [WIDTH+1:0]   u_q, u_d;
   logic [CW-1:0]      cnt_q;
   logic               perr_q;
   logic               busy_q, done_q, err_q;
   logic [WIDTH-1:0]   result_q;

   // DPC radix-2 Montgomery steps chained combinationally. Two guard bits
   // keep every intermediate exact: u < 2P, so u + b < 3P and u + b + P < 4P.
   always_comb begin
      logic [WIDTH+1:0] t;
      t   = '0;
      u_d = u_q;
      for (int i = 0; i < DPC; i++) begin
         t   = u_d + (a_q[i] ? {2'b00, b_q} : {(WIDTH+2){1'b0}});
         t   = t + (t[0] ? {2'b00, p_q} : {(WIDTH+2){1'b0}});
         u_d = t >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         p_q      <= '0;
         u_q      <= '0;
         cnt_q    <= '0;
         perr_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  p_q     <= P;
                  u_q     <= '0;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  perr_q  <= ~P[0];
                  busy_q  <= 1'b1;
                  // An even modulus has no Montgomery inverse: skip straight
                  // to FINAL and report the error there.
                  state_q <= P[0] ? S_CALC : S_FINAL;
               end
            end
            S_CALC: begin
               u_q   <= u_d;
               a_q   <= a_q >> DPC;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == C_LAST) begin
                  state_q <= S_FINAL;
               end
            end
            S_FINAL: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
               if (perr_q) begin
                  err_q    <= 1'b1;
                  result_q <= '0;
               end else begin
                  // u < 2P, so one conditional subtraction fully reduces it
                  // and the reduced value always fits in WIDTH bits.
                  err_q    <= 1'b0;
                  result_q <= WIDTH'((u_q >= {2'b00, p_q}) ? (u_q - {2'b00, p_q}) : u_q);
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mont_mul_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mont_mul_param
//  Purpose  : Directed self-checking bench for mont_mul_param. It uses four
//             instances: 8-bit with DPC=1 and DPC=2, and 255-bit with DPC=5
//             and DPC=1. Expected values are computed by hand.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mont_mul_param;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // 8-bit instances share their operands and have separate start inputs.
   logic         s8a = 1'b0, s8b = 1'b0;
   logic [7:0]   a8 = '0, b8 = '0, p8 = '0;
   logic         bz8a, dn8a, er8a, bz8b, dn8b, er8b;
   logic [7:0]   r8a, r8b;

   // 255-bit instances.
   logic         s25a = 1'b0, s25b = 1'b0;
   logic [254:0] a25 = '0, b25 = '0, p25 = '0;
   logic         bz25a, dn25a, er25a, bz25b, dn25b, er25b;
   logic [254:0] r25a, r25b;

   mont_mul_param #(.WIDTH(8), .DPC(1)) u_w8d1 (
      .clk(clk), .reset(reset), .start(s8a), .a(a8), .b(b8), .P(p8),
      .busy(bz8a), .done(dn8a), .err(er8a), .result(r8a));
   mont_mul_param #(.WIDTH(8), .DPC(2)) u_w8d2 (
      .clk(clk), .reset(reset), .start(s8b), .a(a8), .b(b8), .P(p8),
      .busy(bz8b), .done(dn8b), .err(er8b), .result(r8b));
   mont_mul_param #(.WIDTH(255), .DPC(5)) u_w255d5 (
      .clk(clk), .reset(reset), .start(s25a), .a(a25), .b(b25), .P(p25),
      .busy(bz25a), .done(dn25a), .err(er25a), .result(r25a));
   mont_mul_param #(.WIDTH(255), .DPC(1)) u_w255d1 (
      .clk(clk), .reset(reset), .start(s25b), .a(a25), .b(b25), .P(p25),
      .busy(bz25b), .done(dn25b), .err(er25b), .result(r25b));

   int n_cmp = 0;
   int n_bad = 0;

   // Stimulus helper for the 8-bit instances. It pulses start, then counts
   // cycles until done (bounded). It returns the latency, busy in the first
   // cycle after the start edge, and busy in the cycle just before done.
   task automatic go8(input bit sel2, input logic [7:0] av, bv, pv,
                      output int lat, output logic bz_first, output logic bz_last);
      logic bz_prev;
      @(negedge clk);
      a8 = av; b8 = bv; p8 = pv;
      if (sel2) s8b = 1'b1; else s8a = 1'b1;
      @(posedge clk); #1;
      s8a = 1'b0; s8b = 1'b0;
      bz_first = sel2 ? bz8b : bz8a;
      bz_prev  = bz_first;
      bz_last  = 1'b0;
      lat = 0;
      while (lat < 400) begin
         bz_prev = sel2 ? bz8b : bz8a;
         @(posedge clk); #1;
         lat++;
         if (sel2 ? dn8b : dn8a) begin
            bz_last = bz_prev;
            break;
         end
      end
   endtask

   task automatic go255(input bit sel1, input logic [254:0] av, bv, pv, output int lat);
      @(negedge clk);
      a25 = av; b25 = bv; p25 = pv;
      if (sel1) s25b = 1'b1; else s25a = 1'b1;
      @(posedge clk); #1;
      s25a = 1'b0; s25b = 1'b0;
      lat = 0;
      while (lat < 400) begin
         @(posedge clk); #1;
         lat++;
         if (sel1 ? dn25b : dn25a) break;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({bz8a, dn8a, er8a, r8a} !== 11'd0) begin
         n_bad++; $display("FAIL reset_w8d1 got=%h want=0", {bz8a, dn8a, er8a, r8a});
      end
      n_cmp++;
      if ({bz8b, dn8b, er8b, r8b} !== 11'd0) begin
         n_bad++; $display("FAIL reset_w8d2 got=%h want=0", {bz8b, dn8b, er8b, r8b});
      end
      n_cmp++;
      if ({bz25a, dn25a, er25a, r25a, bz25b, dn25b, er25b, r25b} !== 516'd0) begin
         n_bad++; $display("FAIL reset_w255 got nonzero outputs");
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_dpc1_basic();
      int lat; logic bf, bl;
      go8(1'b0, 8'd5, 8'd7, 8'd13, lat, bf, bl);
      n_cmp++;
      if (lat !== 9) begin n_bad++; $display("FAIL d1_latency got=%0d want=9", lat); end
      n_cmp++;
      if (r8a !== 8'd1) begin n_bad++; $display("FAIL d1_result got=%0d want=1", r8a); end
      n_cmp++;
      if (er8a !== 1'b0) begin n_bad++; $display("FAIL d1_err got=%b want=0", er8a); end
      n_cmp++;
      if ({bf, bl, bz8a} !== 3'b110) begin
         n_bad++; $display("FAIL d1_busy got=%b want=110", {bf, bl, bz8a});
      end
   endtask

   task automatic test_dpc2();
      int lat; logic bf, bl;
      go8(1'b1, 8'd12, 8'd12, 8'd13, lat, bf, bl);
      n_cmp++;
      if (lat !== 5) begin n_bad++; $display("FAIL d2_latency got=%0d want=5", lat); end
      n_cmp++;
      if (r8b !== 8'd3) begin n_bad++; $display("FAIL d2_12x12 got=%0d want=3", r8b); end
      go8(1'b1, 8'd9, 8'd11, 8'd13, lat, bf, bl);
      n_cmp++;
      if (r8b !== 8'd11) begin n_bad++; $display("FAIL d2_9x11 got=%0d want=11", r8b); end
      go8(1'b1, 8'd0, 8'd7, 8'd13, lat, bf, bl);
      n_cmp++;
      if (r8b !== 8'd0) begin n_bad++; $display("FAIL d2_0x7 got=%0d want=0", r8b); end
   endtask

   task automatic test_wide();
      int lat;
      logic [254:0] pm;
      pm = {255{1'b1}} - 255'd18;   // 2^255 - 19
      go255(1'b0, 255'd19, 255'd12345, pm, lat);
      n_cmp++;
      if (lat !== 52) begin n_bad++; $display("FAIL w255d5_latency got=%0d want=52", lat); end
      n_cmp++;
      if (r25a !== 255'd12345) begin n_bad++; $display("FAIL w255d5_result got=%0d want=12345", r25a); end
      go255(1'b1, 255'd19, 255'd12345, pm, lat);
      n_cmp++;
      if (lat !== 256) begin n_bad++; $display("FAIL w255d1_latency got=%0d want=256", lat); end
      n_cmp++;
      if (r25b !== 255'd12345) begin n_bad++; $display("FAIL w255d1_result got=%0d want=12345", r25b); end
   endtask

   task automatic test_even_modulus();
      int lat; logic bf, bl;
      go8(1'b0, 8'd5, 8'd7, 8'd12, lat, bf, bl);
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL even_latency got=%0d want=1", lat); end
      n_cmp++;
      if ({er8a, r8a} !== 9'h100) begin
         n_bad++; $display("FAIL even_err_result got=%b/%0d want=1/0", er8a, r8a);
      end
      go8(1'b0, 8'd5, 8'd7, 8'd13, lat, bf, bl);
      n_cmp++;
      if ({er8a, r8a} !== 9'h001) begin
         n_bad++; $display("FAIL even_recover got=%b/%0d want=0/1", er8a, r8a);
      end
   endtask

   task automatic test_back_to_back();
      int ndone; int lat;
      ndone = 0;
      @(negedge clk);
      a8 = 8'd5; b8 = 8'd7; p8 = 8'd13; s8a = 1'b1;
      @(posedge clk);                         // start accepted here
      repeat (9) begin                        // start held high across all busy edges
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); p8 = 8'($urandom);
         s8a = 1'b1;
         ndone += int'(dn8a);
      end
      @(negedge clk);                         // done cycle of the first operation
      ndone += int'(dn8a);
      n_cmp++;
      if (ndone !== 1 || dn8a !== 1'b1) begin
         n_bad++; $display("FAIL b2b_single_done got=%0d/%b want=1/1", ndone, dn8a);
      end
      n_cmp++;
      if (r8a !== 8'd1) begin n_bad++; $display("FAIL b2b_first_result got=%0d want=1", r8a); end
      a8 = 8'd12; b8 = 8'd12; p8 = 8'd13; s8a = 1'b1;   // start during the done cycle
      @(posedge clk); #1;
      s8a = 1'b0;
      n_cmp++;
      if ({dn8a, bz8a, r8a} !== {1'b0, 1'b1, 8'd1}) begin
         n_bad++; $display("FAIL b2b_accept got=%b/%b/%0d want=0/1/1", dn8a, bz8a, r8a);
      end
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (dn8a) break;
      end
      n_cmp++;
      if (lat !== 9 || r8a !== 8'd3) begin
         n_bad++; $display("FAIL b2b_second got=lat%0d/%0d want=lat9/3", lat, r8a);
      end
   endtask

   task automatic test_reset_mid_calc();
      int lat; logic bf, bl; int nd;
      @(negedge clk);
      a8 = 8'd12; b8 = 8'd12; p8 = 8'd13; s8a = 1'b1;
      @(posedge clk); #1;
      s8a = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++;
      if ({bz8a, dn8a, er8a, r8a} !== 11'd0) begin
         n_bad++; $display("FAIL midreset_outputs got=%h want=0", {bz8a, dn8a, er8a, r8a});
      end
      nd = 0;
      repeat (15) begin
         @(posedge clk); #1;
         nd += int'(dn8a);
      end
      n_cmp++;
      if (nd !== 0) begin n_bad++; $display("FAIL midreset_stale_done got=%0d want=0", nd); end
      go8(1'b0, 8'd5, 8'd7, 8'd13, lat, bf, bl);
      n_cmp++;
      if (lat !== 9 || r8a !== 8'd1) begin
         n_bad++; $display("FAIL midreset_restart got=lat%0d/%0d want=lat9/1", lat, r8a);
      end
   endtask

   initial begin
      test_reset();
      test_dpc1_basic();
      test_dpc2();
      test_wide();
      test_even_modulus();
      test_back_to_back();
      test_reset_mid_calc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
